// File: rtl/uart_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART transmit scheduler:
//   - default requester count and transfer timeout
//   - width of the owner index (covers up to 8 requesters)
//   - scheduler FSM state encoding
//   - one-hot to index conversion helper
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

    localparam int NREQ_DEFAULT    = 4;
    localparam int TIMEOUT_DEFAULT = 4096;
    localparam int OWNER_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    // Converts a one-hot vector (at most 8 requesters) into its bit index.
    // An all-zero input yields index 0.
    function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [7:0] oh);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx |= OWNER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at index
// ptr and wraps modulo NREQ; the first requester found wins.
// Ports:
//   req    [NREQ-1:0]     request vector
//   ptr    [OWNER_W-1:0]  index where the search begins
//   winner [NREQ-1:0]     one-hot winning requester (zero when none)
//   valid                 at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NREQ-1:0]    winner,
    output logic               valid
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NREQ requesters. Requests are arbitrated
// round-robin in IDLE only; the winner's byte is captured, sent with a held
// send strobe until the start bit appears, and the transfer completes on the
// rising edge of the transmitter's done flag. GAP waits for the done flag to
// fall so one long done pulse cannot complete two transfers. A watchdog
// aborts SEND or WAIT_DONE after TIMEOUT cycles.
// Ports:
//   clk                 system clock (also drives the transmitter baud divider)
//   rst                 asynchronous active-low reset
//   req   [NREQ-1:0]    per-requester request, held until its gnt pulse
//   data  [8*NREQ-1:0]  per-requester byte, slice i = data[8*i+7:8*i]
//   gnt   [NREQ-1:0]    one-cycle one-hot grant (byte captured at that edge)
//   done  [NREQ-1:0]    one-cycle one-hot completion
//   owner [2:0]         requester currently served
//   busy                high outside IDLE
//   timeout_err         one-cycle pulse on an aborted transfer
//   uart_send           send strobe to the transmitter (SEND only)
//   uart_dintx [7:0]    byte to the transmitter
//   uart_tx             transmitter serial line (start-bit detection)
//   uart_donetx         transmitter completion flag
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 uart_send,
    output logic [7:0]           uart_dintx,
    input  logic                 uart_tx,
    input  logic                 uart_donetx
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state, state_d;
    logic [OWNER_W-1:0] rr_ptr;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               donetx_q;

    logic [NREQ-1:0]    win_oh;
    logic               win_valid;
    logic [OWNER_W-1:0] win_idx;

    logic               grant_now;
    logic               done_now;
    logic               tmo_now;
    logic               cnt_clr;
    logic               done_rise;
    logic               tmo_hit;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (win_oh),
        .valid  (win_valid)
    );

    assign win_idx   = onehot_to_idx(8'(win_oh));
    assign done_rise = uart_donetx & ~donetx_q;
    // The counter reads TIMEOUT-1 during the TIMEOUT-th cycle in the state.
    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    assign busy      = (state != ST_IDLE);
    assign uart_send = (state == ST_SEND);

    // NOTE: state and datapath registers use non-blocking assignments and an
    // asynchronous reset, so every flop updates from pre-edge values and the
    // reset takes effect without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d   = state;
        grant_now = 1'b0;
        done_now  = 1'b0;
        tmo_now   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_now = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                // Start bit seen: the transmitter has taken the byte.
                if (!uart_tx) begin
                    cnt_clr = 1'b1;
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    tmo_now = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (done_rise) begin
                    done_now = 1'b1;
                    state_d  = ST_GAP;
                end else if (tmo_hit) begin
                    tmo_now = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!uart_donetx) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            owner       <= '0;
            uart_dintx  <= '0;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            donetx_q    <= 1'b0;
        end else begin
            gnt         <= grant_now ? win_oh : '0;
            done        <= done_now ? (NREQ'(1) << owner) : '0;
            timeout_err <= tmo_now;
            donetx_q    <= uart_donetx;

            // Byte and owner are loaded only at grant, which keeps them stable
            // through SEND, WAIT_DONE and GAP.
            if (grant_now) begin
                owner      <= win_idx;
                uart_dintx <= data[8*win_idx +: 8];
                rr_ptr     <= (win_idx == OWNER_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end

            if (cnt_clr)
                tmo_cnt <= '0;
            else if (state == ST_SEND || state == ST_WAIT_DONE)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule
